// File: rtl/dmem_access_ctrl_pkg.sv
// Shared load/store encodings for the memory-access stage, load-alignment unit and decoder.
// Holds the funct3 values, the fault cause codes and the access-stage state codes.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_FUNCT3   = 2'b10,
    CAUSE_RANGE    = 2'b11
  } fault_cause_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_store_lane_gen.sv
// Store lane generator: byte-write enables and lane-replicated write data
// from the store width, the byte offset within the word and right-justified rs2.
module store_lane_gen
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  web,
  output logic [31:0] dinb
);

  always_comb begin
    web  = 4'b0000;
    dinb = wdata;
    case (funct3)
      F3_SB: begin
        web  = 4'b0001 << offset;
        dinb = {4{wdata[7:0]}};
      end
      F3_SH: begin
        web  = 4'b0011 << offset;
        dinb = {2{wdata[15:0]}};
      end
      F3_SW: begin
        web  = 4'b1111;
        dinb = wdata;
      end
      default: begin
        web  = 4'b0000;
        dinb = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access stage: request checking, BRAM port-B drive and load response holding.
//   state | meaning
//   IDLE  | ready for a request; stores and rejected requests complete here in one cycle
//   WAIT  | load issued, counting out the BRAM read latency
//   RESP  | raw load word held until the consumer takes it
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DEPTH_W = 12,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               enb,
  output logic [3:0]         web,
  output logic [DEPTH_W-1:0] addrb,
  output logic [31:0]        dinb,
  input  logic [31:0]        doutb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_word,
  output logic [31:0]        rsp_addr,
  output logic [2:0]         rsp_funct3,
  output logic               store_done,
  output logic               fault,
  output logic [1:0]         fault_cause
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  logic [1:0]   state;
  logic [1:0]   wait_cnt;
  logic         accept;
  logic         bad_f3;
  logic         bad_range;
  logic         bad_align;
  logic         legal;
  fault_cause_e cause_nxt;
  logic [3:0]   lane_web;
  logic [31:0]  lane_dinb;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  assign bad_f3    = !funct3_legal(req_we, req_funct3);
  assign bad_range = |req_addr[31:DEPTH_W+2];
  // Width is taken from funct3[1:0]; illegal widths are already rejected by bad_f3.
  assign bad_align = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign legal     = !(bad_f3 || bad_range || bad_align);

  always_comb begin
    if (bad_f3)
      cause_nxt = CAUSE_FUNCT3;
    else if (bad_range)
      cause_nxt = CAUSE_RANGE;
    else
      cause_nxt = CAUSE_MISALIGN;
  end

  store_lane_gen u_store_lane_gen (
    .funct3 (req_funct3),
    .offset (req_addr[1:0]),
    .wdata  (req_wdata),
    .web    (lane_web),
    .dinb   (lane_dinb)
  );

  assign enb   = accept && legal;
  assign web   = (enb && req_we) ? lane_web : 4'b0000;
  assign addrb = req_addr[DEPTH_W+1:2];
  assign dinb  = lane_dinb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= 2'd0;
      store_done  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      rsp_word    <= 32'd0;
      rsp_addr    <= 32'd0;
      rsp_funct3  <= 3'd0;
    end else begin
      store_done <= accept && legal && req_we;
      fault      <= accept && !legal;
      if (accept && !legal)
        fault_cause <= cause_nxt;

      case (state)
        ST_IDLE: begin
          if (accept && legal && !req_we) begin
            state      <= ST_WAIT;
            wait_cnt   <= WAIT_INIT;
            rsp_addr   <= req_addr;
            rsp_funct3 <= req_funct3;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_word <= doutb;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: two instances (RD_LAT 1 and 2), each with a BRAM model of matching latency.
// Expected load responses are queued when the load is issued and popped when rsp_valid appears.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    logic [2:0]  f3;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_we      [2];
  logic [2:0]  req_funct3  [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic        enb         [2];
  logic [3:0]  web         [2];
  logic [11:0] addrb       [2];
  logic [31:0] dinb        [2];
  logic [31:0] doutb       [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [31:0] rsp_word    [2];
  logic [31:0] rsp_addr    [2];
  logic [2:0]  rsp_funct3  [2];
  logic        store_done  [2];
  logic        fault       [2];
  logic [1:0]  fault_cause [2];

  int   errors = 0;
  int   checks = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [0:4095];
    logic [31:0] rd0;
    logic [31:0] rd1;

    dmem_access_ctrl #(.DEPTH_W(12), .RD_LAT(g + 1)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .req_funct3  (req_funct3[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .enb         (enb[g]),
      .web         (web[g]),
      .addrb       (addrb[g]),
      .dinb        (dinb[g]),
      .doutb       (doutb[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_word    (rsp_word[g]),
      .rsp_addr    (rsp_addr[g]),
      .rsp_funct3  (rsp_funct3[g]),
      .store_done  (store_done[g]),
      .fault       (fault[g]),
      .fault_cause (fault_cause[g])
    );

    // Read-first BRAM; instance 1 adds an output register stage.
    always @(posedge clk) begin
      if (enb[g]) begin
        for (int b = 0; b < 4; b++)
          if (web[g][b]) mem[addrb[g]][8*b +: 8] <= dinb[g][8*b +: 8];
        rd0 <= mem[addrb[g]];
      end
      rd1 <= rd0;
    end
    assign doutb[g] = (g == 0) ? rd0 : rd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid[g]  = 1'b1;
    req_we[g]     = we;
    req_funct3[g] = f3;
    req_addr[g]   = addr;
    req_wdata[g]  = wd;
    #1;
  endtask

  task automatic store(input int g, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] exp_web,
                       input logic [31:0] exp_dinb);
    logic [11:0] exp_addrb;
    exp_addrb = addr[13:2];
    issue(g, 1'b1, f3, addr, wd);
    chk("st_ready", 32'(req_ready[g]), 1);
    chk("st_enb",   32'(enb[g]), 1);
    chk("st_web",   32'(web[g]), 32'(exp_web));
    chk("st_addrb", 32'(addrb[g]), 32'(exp_addrb));
    chk("st_dinb",  dinb[g], exp_dinb);
    tick();
    req_valid[g] = 1'b0;
    chk("st_done",  32'(store_done[g]), 1);
    chk("st_fault", 32'(fault[g]), 0);
    tick();
    chk("st_done_clr", 32'(store_done[g]), 0);
  endtask

  task automatic load(input int g, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp_word, input int hold);
    rsp_t        e;
    int          n;
    logic [11:0] exp_addrb;
    exp_addrb = addr[13:2];
    sb.push_back('{exp_word, addr, f3});
    issue(g, 1'b0, f3, addr, 32'hFFFF_FFFF);
    chk("ld_enb",   32'(enb[g]), 1);
    chk("ld_web",   32'(web[g]), 0);
    chk("ld_addrb", 32'(addrb[g]), 32'(exp_addrb));
    tick();
    req_valid[g] = 1'b0;
    chk("ld_busy", 32'(req_ready[g]), 0);
    n = 0;
    while (!rsp_valid[g] && n < 10) begin
      tick();
      n++;
    end
    chk("ld_latency", n, g + 1);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid[g]), 1);
      chk("hold_ready", 32'(req_ready[g]), 0);
      chk("hold_word",  rsp_word[g], e.word);
    end
    chk("rsp_word", rsp_word[g], e.word);
    chk("rsp_addr", rsp_addr[g], e.addr);
    chk("rsp_f3",   32'(rsp_funct3[g]), 32'(e.f3));
    rsp_ready[g] = 1'b1;
    tick();
    rsp_ready[g] = 1'b0;
    chk("rsp_taken", 32'(rsp_valid[g]), 0);
    chk("rsp_idle",  32'(req_ready[g]), 1);
  endtask

  task automatic bad(input int g, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [1:0] cause);
    issue(g, we, f3, addr, 32'h1234_5678);
    chk("bad_ready", 32'(req_ready[g]), 1);
    chk("bad_enb",   32'(enb[g]), 0);
    chk("bad_web",   32'(web[g]), 0);
    tick();
    req_valid[g] = 1'b0;
    chk("fault_pulse", 32'(fault[g]), 1);
    chk("fault_cause", 32'(fault_cause[g]), 32'(cause));
    chk("bad_idle",    32'(req_ready[g]), 1);
    chk("bad_no_done", 32'(store_done[g]), 0);
    tick();
    chk("fault_clr",  32'(fault[g]), 0);
    chk("cause_held", 32'(fault_cause[g]), 32'(cause));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_valid[g]  = 1'b0;
      req_we[g]     = 1'b0;
      req_funct3[g] = 3'b000;
      req_addr[g]   = 32'd0;
      req_wdata[g]  = 32'd0;
      rsp_ready[g]  = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready",  32'(req_ready[0]), 1);
    chk("rst_valid",  32'(rsp_valid[0]), 0);
    chk("rst_done",   32'(store_done[0]), 0);
    chk("rst_fault",  32'(fault[0]), 0);
    chk("rst_cause",  32'(fault_cause[0]), 0);
    chk("rst_word",   rsp_word[0], 0);
    chk("rst_addr",   rsp_addr[0], 0);
    chk("rst_f3",     32'(rsp_funct3[0]), 0);
    chk("rst_ready1", 32'(req_ready[1]), 1);
    rst = 1'b0;
    tick();

    store(0, F3_SW, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    store(0, F3_SB, 32'h0000_0013, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    load(0, F3_LBU, 32'h0000_0013, 32'hA5AD_BEEF, 0);

    store(0, F3_SW, 32'h0000_0020, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    store(0, F3_SH, 32'h0000_0022, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    load(0, F3_LW, 32'h0000_0020, 32'hBEEF_5678, 5);

    store(1, F3_SW, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    load(1, F3_LW, 32'h0000_0020, 32'hCAFE_F00D, 5);

    bad(0, 1'b0, F3_LH,  32'h0000_0101, 2'b01);
    bad(0, 1'b0, F3_LW,  32'h0001_0000, 2'b11);
    bad(0, 1'b0, 3'b011, 32'h0000_0020, 2'b10);
    bad(0, 1'b1, 3'b100, 32'h0000_0003, 2'b10);
    bad(0, 1'b0, F3_LW,  32'h0000_4001, 2'b11);
    bad(0, 1'b1, F3_SW,  32'h0000_4000, 2'b11);

    store(0, F3_SW, 32'h0000_3FFC, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
    load(0, F3_LHU, 32'h0000_3FFE, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, F3_SW, 32'h40 + 4 * i, 32'h1111_0000 + i);
      chk("b2b_enb",   32'(enb[0]), 1);
      chk("b2b_web",   32'(web[0]), 32'hF);
      chk("b2b_ready", 32'(req_ready[0]), 1);
      tick();
      chk("b2b_done",  32'(store_done[0]), 1);
    end
    req_valid[0] = 1'b0;
    tick();
    chk("b2b_done_clr", 32'(store_done[0]), 0);
    load(0, F3_LW, 32'h0000_004C, 32'h1111_0003, 0);

    issue(1, 1'b0, F3_LW, 32'h0000_0020, 32'h0);
    tick();
    req_valid[1] = 1'b0;
    chk("rw_busy", 32'(req_ready[1]), 0);
    rst = 1'b1;
    #1;
    chk("rw_valid", 32'(rsp_valid[1]), 0);
    chk("rw_ready", 32'(req_ready[1]), 1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw_no_rsp", 32'(rsp_valid[1]), 0);
    end
    load(1, F3_LW, 32'h0000_0020, 32'hCAFE_F00D, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Memory-access stage between the execute pipeline and the data-memory BRAM port B. It accepts one load/store request per handshake and generates BRAM enable, byte-write-enable, word address and lane-replicated write data. For loads, it waits out the BRAM read latency and holds the raw 32-bit word plus the original byte address and funct3 for the downstream load-alignment/extension unit. It also detects misaligned, illegal-funct3 and out-of-range accesses before they reach memory.

Parameters:
DEPTH_W, 12, word-address width of DMEM (2^DEPTH_W words; default 16 KiB)
RD_LAT, 1, BRAM read latency in cycles (1..3; 2 when the BRAM output register is enabled)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2), right-justified
enb  out  1  BRAM port enable
web  out  4  BRAM byte write enables
addrb  out  DEPTH_W  BRAM word address
dinb  out  32  BRAM write data
doutb  in  32  BRAM read data
rsp_valid  out  1  load word available
rsp_ready  in  1  consumer takes response
rsp_word  out  32  raw DMEM word, unshifted
rsp_addr  out  32  original byte address of the load
rsp_funct3  out  3  original funct3 of the load
store_done  out  1  one-cycle pulse, store committed
fault  out  1  one-cycle pulse, access rejected
fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 out of range; held until next fault

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=1; rsp_valid=0; store_done=0; fault=0; fault_cause=00; rsp_word/rsp_addr/rsp_funct3=0; wait counter=0. Any in-flight load is dropped and no response is produced.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; counter loads RD_LAT-1 and decrements.
  - RESP: req_ready=0; rsp_valid=1.
- Request checks, priority order:
  - Illegal funct3: loads 011, 110, 111; stores anything other than 000/001/010.
  - Out of range: req_addr[31:DEPTH_W+2] != 0.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - A failing request is accepted (handshake completes), performs no BRAM access (enb=0, web=0), pulses fault the next cycle, updates fault_cause, and stays in IDLE.
- BRAM drive: combinational, only in IDLE on an accepted legal request. enb=1; addrb=req_addr[DEPTH_W+1:2]. Otherwise enb=0 and web=0.
- Store lanes, off=addr[1:0]:
  - SB: web=0001<<off; dinb={4{wdata[7:0]}}.
  - SH: web=0011<<off; dinb={2{wdata[15:0]}}.
  - SW: web=1111; dinb=wdata.
- Store timing: the write commits at the accept edge. store_done pulses in the following cycle. State stays IDLE, so back-to-back stores run at one per cycle.
- Load timing: web=0000. On the accept edge, latch rsp_addr and rsp_funct3 and go to WAIT. WAIT lasts RD_LAT cycles. On the edge ending WAIT, capture doutb into rsp_word and go to RESP. rsp_valid rises RD_LAT edges after the accept edge.
- RESP: rsp_word, rsp_addr and rsp_funct3 are held stable while rsp_valid && !rsp_ready. On the edge with rsp_ready=1, return to IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- No wrap-around: the top word 2^DEPTH_W-1 is legal, and the next word is out of range.

Decomposition:
- Shared package: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), fault_cause encodings and state encodings. The package is shared with the load-alignment unit and the decoder.
- One natural sub-module: store_lane_gen (combinational: funct3, offset, wdata to web and dinb).
- The FSM, checks and latency counter stay at top level.

Test Plan:
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> enb=1, web=1111, addrb=4, dinb=0xDEADBEEF in the accept cycle; store_done pulses next cycle.
- SB addr 0x0000_0013, wdata 0x0000_00A5 -> web=1000, dinb=0xA5A5A5A5. Follow with LBU at 0x13 -> rsp_word[31:24]=0xA5, rsp_addr=0x13, rsp_funct3=100.
- LW at 0x20, RD_LAT=1 and RD_LAT=2 -> rsp_valid rises exactly 1 and 2 edges after accept. With rsp_ready held 0 for 5 cycles, rsp_word stays stable and req_ready stays 0.
- LH at 0x0000_0101 -> no enb, fault pulses with cause 01. LW at 0x0001_0000 with DEPTH_W=12 -> cause 11. funct3=011 load -> cause 10.
- Assert rst while in WAIT -> rsp_valid stays 0, req_ready=1 immediately, and no response appears after reset release.
- Four back-to-back SW with req_valid held high -> four consecutive web=1111 cycles and four store_done pulses.
